// File: rtl/aes_loader_pkg.sv
// Shared types and sizes for the 512-bit AES stream loader.
// Optional build macro used by the loader: AES_LOADER_BYTESWAP_EN.
package aes_loader_pkg;

    localparam int unsigned WORD_W        = 32;
    localparam int unsigned WORDS_PER_BLK = 16;
    localparam int unsigned BLK_W         = 512;
    localparam int unsigned PTR_W         = 5;

    typedef enum logic [1:0] {
        FILL,
        SETTLE,
        PRESENT
    } loader_state_t;

    function automatic logic [WORD_W-1:0] byte_swap32(input logic [WORD_W-1:0] w);
        return {w[7:0], w[15:8], w[23:16], w[31:24]};
    endfunction

endpackage

// File: rtl/aes_word_bank.sv
// 16x32 register bank with its own write pointer and full flag; word k fills bits [32k +: 32].
// RestartOnFull makes a write into a full bank start a new load at word 0.
module aes_word_bank
    import aes_loader_pkg::*;
#(
    parameter bit RestartOnFull = 1'b0
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              clear_ptr_i,
    input  logic              we_i,
    input  logic [WORD_W-1:0] wdata_i,
    output logic [0:BLK_W-1]  data_o,
    output logic              full_o
);

    logic [0:BLK_W-1] data_q, data_d;
    logic [PTR_W-1:0] ptr_q, ptr_d;

    assign full_o = (ptr_q == PTR_W'(WORDS_PER_BLK));
    assign data_o = data_q;

    always_comb begin
        data_d = data_q;
        ptr_d  = ptr_q;
        if (clear_ptr_i) begin
            ptr_d = '0;
        end else if (we_i) begin
            if (full_o && RestartOnFull) begin
                data_d[0 +: WORD_W] = wdata_i;
                ptr_d               = PTR_W'(1);
            end else if (!full_o) begin
                data_d[WORD_W*ptr_q[3:0] +: WORD_W] = wdata_i;
                ptr_d                               = ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_q <= '0;
            ptr_q  <= '0;
        end else begin
            data_q <= data_d;
            ptr_q  <= ptr_d;
        end
    end

endmodule

// File: rtl/aes_stream_loader_512.sv
// Assembles a 512-bit ciphertext block and key from a 32-bit stream, settles, then presents it.
// Define AES_LOADER_BYTESWAP_EN to byte-reverse every accepted word before storage.
module aes_stream_loader_512
    import aes_loader_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      in_data,
    input  logic             in_valid,
    input  logic             in_is_key,
    output logic             in_ready,
    output logic [0:BLK_W-1] enc_data,
    output logic [0:BLK_W-1] cipher_key,
    output logic             key_loaded,
    output logic             blk_valid,
    input  logic             blk_ready
);

    localparam logic [7:0] SettleLoad = 8'((SETTLE_CYCLES == 0) ? 0 : SETTLE_CYCLES - 1);

    loader_state_t     state_q;
    logic [7:0]        cnt_q;
    logic              data_full;
    logic              accept;
    logic              data_we;
    logic              key_we;
    logic              data_clr;
    logic [WORD_W-1:0] word;

`ifdef AES_LOADER_BYTESWAP_EN
    assign word = byte_swap32(in_data);
`else
    assign word = in_data;
`endif

    // Key words are never back-pressured in FILL, so a fresh key can follow a full data bank.
    assign in_ready  = !rst && (state_q == FILL) && (in_is_key || !data_full);
    assign blk_valid = (state_q == PRESENT);
    assign accept    = in_valid && in_ready;
    assign data_we   = accept && !in_is_key;
    assign key_we    = accept && in_is_key;
    assign data_clr  = (state_q == PRESENT) && blk_ready;

    aes_word_bank #(
        .RestartOnFull(1'b0)
    ) u_data_bank (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_ptr_i (data_clr),
        .we_i        (data_we),
        .wdata_i     (word),
        .data_o      (enc_data),
        .full_o      (data_full)
    );

    aes_word_bank #(
        .RestartOnFull(1'b1)
    ) u_key_bank (
        .clk_i       (clk),
        .rst_i       (rst),
        .clear_ptr_i (1'b0),
        .we_i        (key_we),
        .wdata_i     (word),
        .data_o      (cipher_key),
        .full_o      (key_loaded)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FILL;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (data_full && key_loaded) begin
                        if (SETTLE_CYCLES == 0) begin
                            state_q <= PRESENT;
                        end else begin
                            state_q <= SETTLE;
                            cnt_q   <= SettleLoad;
                        end
                    end
                end
                SETTLE: begin
                    if (cnt_q == 8'd0) begin
                        state_q <= PRESENT;
                    end else begin
                        cnt_q <= cnt_q - 8'd1;
                    end
                end
                PRESENT: begin
                    if (blk_ready) begin
                        state_q <= FILL;
                    end
                end
                default: state_q <= FILL;
            endcase
        end
    end

endmodule

// File: doc/aes_stream_loader_512.md
# aes_stream_loader_512

Upstream feeder for the 512-bit four-lane AES decryptor. Accepts 32-bit words on a valid/ready stream, assembles a 512-bit ciphertext block and a 512-bit key, holds both stable for a programmable settle window while the combinational decryptor resolves, then offers the block downstream with a valid/ready handshake. The key persists across blocks until it is reloaded.

## Interface

Parameters:
- SETTLE_CYCLES, 4, cycles `enc_data`/`cipher_key` are held stable before `blk_valid` rises; legal range 0..255.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  32  input word.
- in_valid  in  1  `in_data` is valid.
- in_is_key  in  1  1: word targets the key bank; 0: word targets the data bank.
- in_ready  out  1  word accepted this cycle when `in_valid & in_ready`.
- enc_data  out  512  assembled ciphertext, bit 0 is MSB (`[0:511]`).
- cipher_key  out  512  assembled key, `[0:511]`.
- key_loaded  out  1  all 16 key words present.
- blk_valid  out  1  block ready for downstream.
- blk_ready  in  1  downstream consumes the block.

## Operation

- States: FILL, SETTLE, PRESENT. Reset state is FILL.
- Bank write order: word k (k = 0..15) is written to bits [32k +: 32], so word 0 lands in bits [0:31].
- Each bank has its own 5-bit write pointer (`dptr`, `kptr`).

In FILL:
- `in_ready = in_is_key ? 1 : (dptr != 16)`.
- An accepted data word writes the data bank at `dptr`, then `dptr` increments.
- An accepted key word writes the key bank at `kptr`, then `kptr` increments.
- When `kptr` reaches 16, `key_loaded` goes to 1.
- A key word accepted while `key_loaded = 1` restarts the key load:
  - it is written to word 0;
  - `kptr` becomes 1;
  - `key_loaded` drops to 0 in the same cycle.
- Leaving FILL requires `dptr == 16 && key_loaded == 1`, evaluated on registered values.
  - If `SETTLE_CYCLES > 0`, go to SETTLE and load the settle counter with `SETTLE_CYCLES - 1`.
  - If `SETTLE_CYCLES == 0`, go directly to PRESENT.
- If data is full but the key is incomplete, stay in FILL. Data words are back-pressured; key words are still accepted.

In SETTLE:
- `in_ready = 0`.
- The counter decrements each cycle.
- When the counter is 0, go to PRESENT next cycle.

In PRESENT:
- `blk_valid = 1`, `in_ready = 0`.
- On `blk_ready`, go to FILL with `dptr = 0`. The key bank, `kptr` and `key_loaded` are unchanged.

General rules:
- `enc_data` and `cipher_key` never change outside FILL.
- Reset, at any state: clears state to FILL, `dptr`, `kptr`, `key_loaded`, the settle counter, and both banks to 0.
- Reset mid-block discards any partial data or key.

## Timing

- Reset values:
  - `enc_data`, `cipher_key`, `key_loaded`, `blk_valid` are 0.
  - `in_ready` is forced to 0 while `rst` is high.
- Outputs: `enc_data` and `cipher_key` are driven directly from registers. `blk_valid` and `in_ready` are decoded from the state and pointer registers.
- Latency: the last required word is accepted at edge t. `blk_valid` rises after edge t + 1 + SETTLE_CYCLES.
- `blk_valid` stays high until it is sampled with `blk_ready = 1`, then falls on the next edge.
- First FILL accept is possible in the cycle after that handshake edge.
- Minimum block period: 16 data-word cycles + 1 + SETTLE_CYCLES + 1 handshake cycle.

## Configuration

- `AES_LOADER_BYTESWAP_EN`
  - Defined: every accepted word (data and key) is byte-reversed before storage. `in_data[7:0]` becomes the first byte of the word slot.
  - Undefined: words are stored as received, with `in_data[31:24]` as the first byte.
- Pointer, handshake and timing behaviour are identical in both builds.

## Structure

Package `aes_loader_pkg`:
- State enum `loader_state_t` {FILL, SETTLE, PRESENT}.
- `WORD_W = 32`, `WORDS_PER_BLK = 16`, `BLK_W = 512`.

Sub-module `aes_word_bank`:
- 16×32 register bank plus write pointer and full flag.
- Synchronous clear, and a restart-on-write-when-full option.
- Instantiated twice: data bank and key bank.

## Test plan

- **Reset:** hold `rst` for 3 cycles with `in_valid = 1` → `in_ready`, `blk_valid`, `key_loaded` are 0; both buses are 0 throughout.
- **Basic block:** 16 key words 0x00010203…, then 16 data words 0xA0000000+k, SETTLE_CYCLES = 4, `blk_ready` held 1 →
  - `enc_data[0:31] = 0xA0000000` and `enc_data[480:511] = 0xA000000F`;
  - `blk_valid` rises exactly 5 cycles after the last accept and is high for 1 cycle.
- **Back-pressure:** 16 data words first, key absent →
  - a 17th data word sees `in_ready = 0`;
  - key words are accepted;
  - `blk_valid` follows 5 cycles after the 16th key word.
- **Hold and reuse:** keep `blk_ready = 0` for 10 cycles in PRESENT →
  - buses are stable and `in_ready = 0`;
  - after the handshake, a second 16-word data block reuses the key without reloading (`key_loaded` stays 1).
- **Key reload and SETTLE_CYCLES = 0:** a key word sent after a full key → `key_loaded` drops to 0 and the word lands in `cipher_key[0:31]`. With SETTLE_CYCLES = 0, `blk_valid` rises 1 cycle after the last accept.
- **Byte swap build:** with `AES_LOADER_BYTESWAP_EN` defined, data word 0x11223344 → `enc_data[0:31] = 0x44332211`. Mid-SETTLE reset → returns to FILL with all outputs 0.
